// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: digit encoding and FSM states.
package booth_pkg;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Map the multiplier window {b[2i+1], b[2i], b[2i-1]} to a Booth digit.
  function automatic booth_op_e booth_encode(input logic [2:0] win);
    booth_op_e op;
    case (win)
      3'b001, 3'b010: op = POS1;
      3'b011:         op = POS2;
      3'b100:         op = NEG2;
      3'b101, 3'b110: op = NEG1;
      default:        op = ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial-product selector: 0, +/-A or +/-2A, sign-extended
// to WIDTH+4 bits so that -2A of the most negative extended operand still fits.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  booth_op_e                 op,
  input  logic        [WIDTH+1:0]   a,
  output logic signed [WIDTH+3:0]   pp
);

  localparam int PW = WIDTH + 4;

  logic [PW-1:0] a1_s;
  logic [PW-1:0] a2_s;
  logic [PW-1:0] one_s;

  assign a1_s  = {{2{a[WIDTH+1]}}, a};
  assign a2_s  = {a1_s[PW-2:0], 1'b0};
  assign one_s = {{(PW-1){1'b0}}, 1'b1};

  // Select the digit multiple; negation is invert-plus-one.
  always_comb begin
    pp = '0;
    case (op)
      POS1:    pp = a1_s;
      POS2:    pp = a2_s;
      NEG1:    pp = ~a1_s + one_s;
      NEG2:    pp = ~a2_s + one_s;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier: one digit per clock into an accumulator,
// signed or unsigned operands, start/busy/done handshake.
module booth_r4_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  import booth_pkg::*;

  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N);
  localparam int XW = WIDTH + 2;
  localparam int PW = WIDTH + 4;
  localparam int RW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("booth_r4_seq_mul: WIDTH must be even and >= 4");
  end

  state_e          state_r;
  logic [CW-1:0]   cnt_r;
  logic [XW-1:0]   a_r;
  logic [XW:0]     m_r;     // extended multiplier with b[-1]=0 appended at bit 0
  logic [RW-1:0]   acc_r;

  logic [XW-1:0]          a_ext_s;
  logic [XW-1:0]          b_ext_s;
  booth_op_e              op_s;
  logic signed [PW-1:0]   pp_s;
  logic signed [RW-1:0]   pp_ext_s;
  logic [RW-1:0]          acc_next_s;

  assign a_ext_s = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                               : {2'b00, multiplicand};
  assign b_ext_s = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                               : {2'b00, multiplier};

  assign op_s = booth_encode(m_r[2:0]);

  booth_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
    .op (op_s),
    .a  (a_r),
    .pp (pp_s)
  );

  // Modular accumulation is exact because only the low 2*WIDTH bits are kept.
  assign pp_ext_s   = RW'(pp_s);
  assign acc_next_s = acc_r + (pp_ext_s << {cnt_r, 1'b0});

  // Control FSM with operand capture, digit stepping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      a_r     <= '0;
      m_r     <= '0;
      acc_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a_ext_s;
            m_r     <= {b_ext_s, 1'b0};
            acc_r   <= '0;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          acc_r <= acc_next_s;
          if (cnt_r == LAST) begin
            product <= acc_next_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            m_r   <= {{2{m_r[XW]}}, m_r[XW:2]};
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
